// File: rtl/datapath_pipe.sv
// Parametrised register-file datapath: ALU with registered flags, one-stage
// write-back with operand forwarding, and an iterative shift-add multiplier.
module datapath_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4,
    parameter int SEL_W      = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_enable,
    input  logic [SEL_W-1:0]      dest_select,
    input  logic [SEL_W-1:0]      A_select,
    input  logic [SEL_W-1:0]      B_select,
    input  logic [3:0]            fs,
    input  logic                  md_select,
    input  logic                  mb_select,
    input  logic [DATA_WIDTH-1:0] constant_in,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic [DATA_WIDTH-1:0] Address_out,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic [DATA_WIDTH-1:0] function_result,
    output logic [3:0]            flags,
    output logic                  busy
);

    localparam int MSB   = DATA_WIDTH - 1;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] FS_INC = 4'd1;
    localparam logic [3:0] FS_ADD = 4'd2;
    localparam logic [3:0] FS_SUB = 4'd3;
    localparam logic [3:0] FS_DEC = 4'd4;
    localparam logic [3:0] FS_AND = 4'd5;
    localparam logic [3:0] FS_OR  = 4'd6;
    localparam logic [3:0] FS_XOR = 4'd7;
    localparam logic [3:0] FS_NOT = 4'd8;
    localparam logic [3:0] FS_SHL = 4'd9;
    localparam logic [3:0] FS_SHR = 4'd10;
    localparam logic [3:0] FS_MUL = 4'd11;

    typedef enum logic {
        MUL_IDLE,
        MUL_RUN
    } mul_state_t;

    mul_state_t state, state_next;

    logic [DATA_WIDTH-1:0] rf [NUM_REGS];

    logic                  wb_valid;
    logic [SEL_W-1:0]      wb_dest;
    logic [DATA_WIDTH-1:0] wb_data;

    logic [DATA_WIDTH-1:0] mul_a;
    logic [DATA_WIDTH-1:0] mul_b;
    logic [DATA_WIDTH-1:0] mul_acc;
    logic [DATA_WIDTH-1:0] mul_acc_next;
    logic [SEL_W-1:0]      mul_dest;
    logic [CNT_W-1:0]      mul_cnt;

    logic [DATA_WIDTH-1:0] a_op;
    logic [DATA_WIDTH-1:0] b_reg;
    logic [DATA_WIDTH-1:0] b_op;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH-1:0] alu_f;
    logic                  alu_c;
    logic                  alu_v;
    logic [3:0]            alu_flags;

    logic issue;
    logic mul_start;
    logic mul_last;

    // Pending write-back is visible to readers one edge before it lands.
    assign a_op  = (wb_valid && wb_dest == A_select) ? wb_data : rf[A_select];
    assign b_reg = (wb_valid && wb_dest == B_select) ? wb_data : rf[B_select];
    assign b_op  = mb_select ? constant_in : b_reg;

    assign busy      = (state == MUL_RUN);
    assign issue     = load_enable & ~busy;
    assign mul_start = issue & (fs == FS_MUL) & ~md_select;
    assign mul_last  = busy & (mul_cnt == CNT_W'(DATA_WIDTH - 1));

    assign mul_acc_next = mul_acc + (mul_b[0] ? mul_a : '0);

    always_comb begin
        sum   = '0;
        alu_f = a_op;
        alu_c = 1'b0;
        alu_v = 1'b0;
        unique case (fs)
            FS_INC: begin
                sum   = {1'b0, a_op} + (DATA_WIDTH+1)'(1);
                alu_f = sum[MSB:0];
                alu_c = sum[DATA_WIDTH];
                alu_v = ~a_op[MSB] & alu_f[MSB];
            end
            FS_ADD: begin
                sum   = {1'b0, a_op} + {1'b0, b_op};
                alu_f = sum[MSB:0];
                alu_c = sum[DATA_WIDTH];
                alu_v = (a_op[MSB] == b_op[MSB]) & (alu_f[MSB] != a_op[MSB]);
            end
            FS_SUB: begin
                sum   = {1'b0, a_op} + {1'b0, ~b_op} + (DATA_WIDTH+1)'(1);
                alu_f = sum[MSB:0];
                alu_c = sum[DATA_WIDTH];
                alu_v = (a_op[MSB] != b_op[MSB]) & (alu_f[MSB] != a_op[MSB]);
            end
            FS_DEC: begin
                // A + all-ones: carry-out set unless A was zero (borrow).
                sum   = {1'b0, a_op} + {1'b0, {DATA_WIDTH{1'b1}}};
                alu_f = sum[MSB:0];
                alu_c = sum[DATA_WIDTH];
                alu_v = a_op[MSB] & ~alu_f[MSB];
            end
            FS_AND: alu_f = a_op & b_op;
            FS_OR:  alu_f = a_op | b_op;
            FS_XOR: alu_f = a_op ^ b_op;
            FS_NOT: alu_f = ~a_op;
            FS_SHL: begin
                alu_f = {b_op[MSB-1:0], 1'b0};
                alu_c = b_op[MSB];
            end
            FS_SHR: begin
                alu_f = {1'b0, b_op[MSB:1]};
                alu_c = b_op[0];
            end
            FS_MUL: alu_f = mul_acc;
            default: alu_f = a_op;
        endcase
    end

    assign alu_flags = {alu_v, alu_c, alu_f[MSB], ~|alu_f};

    always_comb begin
        state_next = state;
        unique case (state)
            MUL_IDLE: if (mul_start) state_next = MUL_RUN;
            MUL_RUN:  if (mul_last)  state_next = MUL_IDLE;
            default:  state_next = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= MUL_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
            wb_valid <= 1'b0;
            wb_dest  <= '0;
            wb_data  <= '0;
            flags    <= 4'b0000;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_acc  <= '0;
            mul_dest <= '0;
            mul_cnt  <= '0;
        end else begin
            if (wb_valid) rf[wb_dest] <= wb_data;
            wb_valid <= 1'b0;
            if (busy) begin
                mul_a   <= mul_a << 1;
                mul_b   <= mul_b >> 1;
                mul_cnt <= mul_cnt + CNT_W'(1);
                mul_acc <= mul_last ? '0 : mul_acc_next;
                if (mul_last) begin
                    wb_valid <= 1'b1;
                    wb_dest  <= mul_dest;
                    wb_data  <= mul_acc_next;
                    flags    <= {2'b00, mul_acc_next[MSB], ~|mul_acc_next};
                end
            end else if (mul_start) begin
                mul_a    <= a_op;
                mul_b    <= b_op;
                mul_acc  <= '0;
                mul_dest <= dest_select;
                mul_cnt  <= '0;
            end else if (issue) begin
                wb_valid <= 1'b1;
                wb_dest  <= dest_select;
                wb_data  <= md_select ? Data_in : alu_f;
                if (!md_select) flags <= alu_flags;
            end
        end
    end

    assign Address_out     = a_op;
    assign Data_out        = b_op;
    assign function_result = alu_f;

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: directed vector table, multi-cycle corner
// sequences, and a randomized run against an architectural reference model.
module tb_datapath_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_enable;
    logic [1:0]  dest_select;
    logic [1:0]  A_select;
    logic [1:0]  B_select;
    logic [3:0]  fs;
    logic        md_select;
    logic        mb_select;
    logic [31:0] constant_in;
    logic [31:0] Data_in;
    logic [31:0] Address_out;
    logic [31:0] Data_out;
    logic [31:0] function_result;
    logic [3:0]  flags;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    datapath_pipe #(.DATA_WIDTH(32), .NUM_REGS(4)) dut (
        .clk(clk), .reset(reset), .load_enable(load_enable),
        .dest_select(dest_select), .A_select(A_select), .B_select(B_select),
        .fs(fs), .md_select(md_select), .mb_select(mb_select),
        .constant_in(constant_in), .Data_in(Data_in),
        .Address_out(Address_out), .Data_out(Data_out),
        .function_result(function_result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  fs;
        logic [31:0] a;
        logic [31:0] b;
        logic        mb;
        logic [31:0] k;
        logic [31:0] ef;
        logic [3:0]  efl;
    } vec_t;

    vec_t vecs [16];

    // Architectural model: a write is visible to reads right after its issue edge.
    logic [31:0] arch [4];
    logic [3:0]  m_flags;
    logic        m_busy;
    int          m_steps;
    logic [31:0] m_ma, m_mb;
    logic [1:0]  m_dest;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] d, input logic [1:0] as, input logic [1:0] bs,
                         input logic [3:0] f, input logic md, input logic mb,
                         input logic [31:0] k, input logic [31:0] din);
        load_enable = 1'b1;
        dest_select = d;
        A_select = as;
        B_select = bs;
        fs = f;
        md_select = md;
        mb_select = mb;
        constant_in = k;
        Data_in = din;
        tick();
        load_enable = 1'b0;
    endtask

    task automatic load(input logic [1:0] d, input logic [31:0] v);
        issue(d, 2'd0, 2'd0, 4'd0, 1'b1, 1'b0, 32'h0, v);
    endtask

    function automatic void ref_alu(input logic [3:0] f, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic [3:0] fl);
        longint sa, sb, sr;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = 0;
        c = 1'b0;
        r = a;
        case (f)
            4'd1: begin r = a + 1; c = (a == 32'hFFFF_FFFF); sr = sa + 1; end
            4'd2: begin
                r = a + b;
                c = ({32'h0, a} + {32'h0, b}) > 64'hFFFF_FFFF;
                sr = sa + sb;
            end
            4'd3: begin r = a - b; c = (a >= b); sr = sa - sb; end
            4'd4: begin r = a - 1; c = (a != 0); sr = sa - 1; end
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = ~a;
            4'd9: begin r = b * 2; c = b[31]; end
            4'd10: begin r = b / 2; c = b[0]; end
            default: r = a;
        endcase
        v = (f >= 4'd1 && f <= 4'd4) &&
            (sr > 64'sd2147483647 || sr < -64'sd2147483648);
        fl = {v, c, r[31], r == 32'h0};
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] r;
        case ($urandom_range(0, 5))
            0: r = 32'h0;
            1: r = 32'hFFFF_FFFF;
            2: r = 32'h8000_0000;
            3: r = 32'h7FFF_FFFF;
            default: r = $urandom;
        endcase
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ef, ea, eb, prod;
        logic [3:0]  efl;
        logic [63:0] mask, p64;
        int          nbusy;

        vecs[0]  = '{4'd2,  32'h1A2B3C4D, 32'h0,        1'b1, 32'h5E6F789A, 32'h789AB4E7, 4'b0000};
        vecs[1]  = '{4'd3,  32'h80000000, 32'h00000001, 1'b0, 32'h0, 32'h7FFFFFFF, 4'b1100};
        vecs[2]  = '{4'd3,  32'h00000001, 32'h00000001, 1'b0, 32'h0, 32'h00000000, 4'b0101};
        vecs[3]  = '{4'd1,  32'h7FFFFFFF, 32'h0,        1'b0, 32'h0, 32'h80000000, 4'b1010};
        vecs[4]  = '{4'd1,  32'hFFFFFFFF, 32'h0,        1'b0, 32'h0, 32'h00000000, 4'b0101};
        vecs[5]  = '{4'd4,  32'h00000000, 32'h0,        1'b0, 32'h0, 32'hFFFFFFFF, 4'b0010};
        vecs[6]  = '{4'd4,  32'h80000000, 32'h0,        1'b0, 32'h0, 32'h7FFFFFFF, 4'b1100};
        vecs[7]  = '{4'd5,  32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h0, 32'h00F000F0, 4'b0000};
        vecs[8]  = '{4'd6,  32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 32'h0, 32'hFFFFFFFF, 4'b0010};
        vecs[9]  = '{4'd7,  32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0, 32'h0, 32'h00000000, 4'b0001};
        vecs[10] = '{4'd8,  32'h00000000, 32'h0,        1'b0, 32'h0, 32'hFFFFFFFF, 4'b0010};
        vecs[11] = '{4'd9,  32'h0,        32'h80000001, 1'b0, 32'h0, 32'h00000002, 4'b0100};
        vecs[12] = '{4'd10, 32'h0,        32'h00000003, 1'b0, 32'h0, 32'h00000001, 4'b0100};
        vecs[13] = '{4'd0,  32'h00000000, 32'h0,        1'b0, 32'h0, 32'h00000000, 4'b0001};
        vecs[14] = '{4'd13, 32'h12345678, 32'h0,        1'b0, 32'h0, 32'h12345678, 4'b0000};
        vecs[15] = '{4'd2,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 32'h00000000, 4'b0101};

        reset = 1'b1;
        load_enable = 1'b0;
        dest_select = '0;
        A_select = '0;
        B_select = '0;
        fs = '0;
        md_select = 1'b0;
        mb_select = 1'b0;
        constant_in = 32'h0;
        Data_in = 32'h0;
        @(negedge clk);
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        mb_select = 1'b1;
        constant_in = 32'hC0FFEE11;
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_flags", {28'h0, flags}, 32'h0);
        chk("rst_dout_const", Data_out, 32'hC0FFEE11);
        for (int i = 0; i < 4; i++) begin
            A_select = 2'(i);
            #1;
            chk("rst_reg", Address_out, 32'h0);
        end
        mb_select = 1'b0;

        // Memory loads, visible forwarded then from the register file
        begin
            logic [31:0] lv [4];
            lv[0] = 32'h1A2B3C4D;
            lv[1] = 32'h5A5A5A5A;
            lv[2] = 32'hABCDEF01;
            lv[3] = 32'h9ABCDEF0;
            for (int i = 0; i < 4; i++) begin
                load(2'(i), lv[i]);
                A_select = 2'(i);
                #1;
                chk("load_fwd", Address_out, lv[i]);
                tick();
                chk("load_rf", Address_out, lv[i]);
                chk("load_flags", {28'h0, flags}, 32'h0);
            end
        end

        // Vector table: R0=a, R1=b, op into R2, read back forwarded
        for (int i = 0; i < 16; i++) begin
            load(2'd0, vecs[i].a);
            load(2'd1, vecs[i].b);
            load_enable = 1'b1;
            dest_select = 2'd2;
            A_select = 2'd0;
            B_select = 2'd1;
            fs = vecs[i].fs;
            md_select = 1'b0;
            mb_select = vecs[i].mb;
            constant_in = vecs[i].k;
            #1;
            chk("vec_f", function_result, vecs[i].ef);
            tick();
            load_enable = 1'b0;
            A_select = 2'd2;
            #1;
            chk("vec_r2", Address_out, vecs[i].ef);
            chk("vec_flags", {28'h0, flags}, {28'h0, vecs[i].efl});
        end

        // Back-to-back dependent issue with no bubble
        load(2'd2, 32'h00000005);
        load_enable = 1'b1;
        dest_select = 2'd3;
        A_select = 2'd2;
        fs = 4'd1;
        md_select = 1'b0;
        mb_select = 1'b0;
        #1;
        chk("fwd_f", function_result, 32'h00000006);
        tick();
        load_enable = 1'b0;
        A_select = 2'd3;
        #1;
        chk("fwd_r3", Address_out, 32'h00000006);

        // Multiply with busy window and an ignored mid-busy load
        load(2'd0, 32'h00001234);
        load(2'd1, 32'h00000010);
        load(2'd3, 32'hCAFE0000);
        issue(2'd2, 2'd0, 2'd1, 4'd11, 1'b0, 1'b0, 32'h0, 32'h0);
        nbusy = 0;
        for (int c = 0; c < 40 && busy; c++) begin
            nbusy++;
            if (c == 5) begin
                load_enable = 1'b1;
                dest_select = 2'd3;
                md_select = 1'b1;
                Data_in = 32'hDEADBEEF;
            end else begin
                load_enable = 1'b0;
                md_select = 1'b0;
            end
            tick();
        end
        load_enable = 1'b0;
        md_select = 1'b0;
        fs = 4'd11;
        chk("mul_busy_cycles", nbusy, 32);
        A_select = 2'd2;
        #1;
        chk("mul_product", Address_out, 32'h00012340);
        chk("mul_flags", {28'h0, flags}, 32'h0);
        chk("mul_idle_f", function_result, 32'h0);
        A_select = 2'd3;
        #1;
        chk("mul_r3_kept", Address_out, 32'hCAFE0000);
        tick();
        A_select = 2'd2;
        #1;
        chk("mul_rf", Address_out, 32'h00012340);

        // Reset in the middle of a multiply
        load(2'd0, 32'h00000003);
        load(2'd1, 32'h00000007);
        issue(2'd2, 2'd0, 2'd1, 4'd11, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (9) tick();
        #1;
        chk("rmul_busy_before", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rmul_busy", {31'h0, busy}, 32'h0);
        chk("rmul_flags", {28'h0, flags}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            A_select = 2'(i);
            #1;
            chk("rmul_reg", Address_out, 32'h0);
        end
        repeat (40) tick();
        A_select = 2'd2;
        #1;
        chk("rmul_no_write", Address_out, 32'h0);
        chk("rmul_busy_late", {31'h0, busy}, 32'h0);

        // Randomized run against the architectural model
        for (int i = 0; i < 4; i++) arch[i] = 32'h0;
        m_flags = 4'b0;
        m_busy = 1'b0;
        m_steps = 0;
        m_ma = 32'h0;
        m_mb = 32'h0;
        m_dest = 2'd0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            load_enable = ($urandom_range(0, 3) != 0);
            dest_select = 2'($urandom_range(0, 3));
            A_select = 2'($urandom_range(0, 3));
            B_select = 2'($urandom_range(0, 3));
            fs = 4'($urandom_range(0, 15));
            md_select = ($urandom_range(0, 3) == 0);
            mb_select = ($urandom_range(0, 1) == 1);
            constant_in = rnd_val();
            Data_in = rnd_val();
            #1;
            ea = arch[A_select];
            eb = mb_select ? constant_in : arch[B_select];
            ref_alu(fs, ea, eb, ef, efl);
            if (fs == 4'd11) begin
                mask = (64'd1 << m_steps) - 64'd1;
                p64 = {32'h0, m_ma} * ({32'h0, m_mb} & mask);
                ef = m_busy ? p64[31:0] : 32'h0;
            end
            chk("rnd_addr", Address_out, ea);
            chk("rnd_dout", Data_out, eb);
            chk("rnd_f", function_result, ef);
            chk("rnd_flags", {28'h0, flags}, {28'h0, m_flags});
            chk("rnd_busy", {31'h0, busy}, {31'h0, m_busy});
            if (m_busy) begin
                m_steps++;
                if (m_steps == 32) begin
                    p64 = {32'h0, m_ma} * {32'h0, m_mb};
                    prod = p64[31:0];
                    arch[m_dest] = prod;
                    m_flags = {2'b00, prod[31], prod == 32'h0};
                    m_busy = 1'b0;
                end
            end else if (load_enable) begin
                if (fs == 4'd11 && !md_select) begin
                    m_busy = 1'b1;
                    m_steps = 0;
                    m_ma = ea;
                    m_mb = eb;
                    m_dest = dest_select;
                end else begin
                    arch[dest_select] = md_select ? Data_in : ef;
                    if (!md_select) m_flags = efl;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
